// File: rtl/switch_core.sv
// Forwarding core: buffers source frames in a first-word fall-through FIFO and
// presents them in order downstream; zero-address frames are dropped and counted.
module switch_core #(
    parameter int ADDR_W = 48,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       src_valid,
    output logic                       src_ready,
    input  logic [ADDR_W-1:0]          src_addr,
    input  logic [DATA_W-1:0]          src_data,
    output logic                       dst_valid,
    input  logic                       dst_ready,
    output logic [ADDR_W-1:0]          dst_addr,
    output logic [DATA_W-1:0]          dst_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  drops;

    logic accept;
    logic push;
    logic drop;
    logic pop;

    assign src_ready  = (level != FULL_LEVEL);
    assign dst_valid  = (level != '0);
    assign fifo_level = level;
    assign drop_cnt   = drops;

    // Popped entries are zeroed, so the head reads 0 whenever the FIFO is empty.
    assign dst_addr = mem_addr[rd_ptr];
    assign dst_data = mem_data[rd_ptr];

    assign accept = src_valid && src_ready;
    assign push   = accept && (src_addr != '0);
    assign drop   = accept && (src_addr == '0);
    assign pop    = dst_valid && dst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
        end else begin
            // Push and pop only share a slot when empty or full, where one of them is blocked.
            if (pop) begin
                mem_addr[rd_ptr] <= '0;
                mem_data[rd_ptr] <= '0;
            end
            if (push) begin
                mem_addr[wr_ptr] <= src_addr;
                mem_data[wr_ptr] <= src_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drops <= '0;
        end else if (drop && (drops != '1)) begin
            drops <= drops + 1'b1;
        end
    end

endmodule

// File: tb/tb_switch_core.sv
// Directed self-checking bench for switch_core: latency, full/backpressure,
// drops, counter saturation, streaming across pointer wrap and mid-run reset.
module tb_switch_core;

    localparam int ADDR_W = 48;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              src_valid;
    logic              src_ready;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_data;
    logic              dst_valid;
    logic              dst_ready;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] dst_data;
    logic [2:0]        fifo_level;
    logic [CNT_W-1:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    switch_core #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_addr(src_addr), .src_data(src_data),
        .dst_valid(dst_valid), .dst_ready(dst_ready),
        .dst_addr(dst_addr), .dst_data(dst_data),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_valid = 1'b0;
        src_addr = '0;
        src_data = '0;
        dst_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level);
        end
        checks++;
        if (dst_valid !== 1'b0 || dst_addr !== '0 || dst_data !== '0) begin
            errors++; $display("FAIL reset_dst got valid=%b addr=%h data=%h exp 0/0/0", dst_valid, dst_addr, dst_data);
        end
        checks++;
        if (src_ready !== 1'b1 || drop_cnt !== '0) begin
            errors++; $display("FAIL reset_src got ready=%b drops=%0d exp 1/0", src_ready, drop_cnt);
        end
    endtask

    task automatic test_single();
        dst_ready = 1'b1;
        src_valid = 1'b1;
        src_addr = 48'h0000_1111_2222;
        src_data = 32'hDEAD_BEEF;
        step();
        src_valid = 1'b0;
        checks++;
        if (dst_valid !== 1'b1 || dst_addr !== 48'h0000_1111_2222 || dst_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_out got valid=%b addr=%h data=%h exp 1/000011112222/deadbeef", dst_valid, dst_addr, dst_data);
        end
        step();
        checks++;
        if (dst_valid !== 1'b0 || dst_addr !== '0 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL single_pop got valid=%b addr=%h level=%0d exp 0/0/0", dst_valid, dst_addr, fifo_level);
        end
    endtask

    task automatic test_full();
        dst_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            src_valid = 1'b1;
            src_addr = ADDR_W'(i);
            src_data = DATA_W'(i * 32'h100);
            step();
        end
        src_addr = 48'd5;
        src_data = 32'h500;
        checks++;
        if (fifo_level !== 3'd4 || src_ready !== 1'b0) begin
            errors++; $display("FAIL full_level got level=%0d ready=%b exp 4/0", fifo_level, src_ready);
        end
        step();
        step();
        checks++;
        if (fifo_level !== 3'd4 || dst_addr !== 48'd1 || dst_data !== 32'h100) begin
            errors++; $display("FAIL full_hold got level=%0d addr=%0d data=%h exp 4/1/100", fifo_level, dst_addr, dst_data);
        end
        dst_ready = 1'b1;
        step();
        checks++;
        if (fifo_level !== 3'd3 || src_ready !== 1'b1 || dst_addr !== 48'd2) begin
            errors++; $display("FAIL full_first_pop got level=%0d ready=%b addr=%0d exp 3/1/2", fifo_level, src_ready, dst_addr);
        end
        step();
        src_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd3 || dst_addr !== 48'd3 || dst_data !== 32'h300) begin
            errors++; $display("FAIL full_refill got level=%0d addr=%0d data=%h exp 3/3/300", fifo_level, dst_addr, dst_data);
        end
        step();
        checks++;
        if (dst_addr !== 48'd4 || dst_data !== 32'h400 || fifo_level !== 3'd2) begin
            errors++; $display("FAIL full_order4 got addr=%0d data=%h level=%0d exp 4/400/2", dst_addr, dst_data, fifo_level);
        end
        step();
        checks++;
        if (dst_addr !== 48'd5 || dst_data !== 32'h500 || fifo_level !== 3'd1) begin
            errors++; $display("FAIL full_order5 got addr=%0d data=%h level=%0d exp 5/500/1", dst_addr, dst_data, fifo_level);
        end
        step();
        checks++;
        if (dst_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL full_drain got valid=%b level=%0d exp 0/0", dst_valid, fifo_level);
        end
    endtask

    task automatic test_drop();
        logic [ADDR_W-1:0] seq [4];
        logic [ADDR_W-1:0] seen_addr [$];
        logic [DATA_W-1:0] seen_data [$];
        int max_level;
        seq[0] = 48'd0; seq[1] = 48'd7; seq[2] = 48'd0; seq[3] = 48'd9;
        max_level = 0;
        dst_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            src_valid = (i < 4);
            src_addr = (i < 4) ? seq[i] : '0;
            src_data = (i < 4) ? DATA_W'(seq[i] * 16 + 48'h1) : '0;
            step();
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (dst_valid) begin
                seen_addr.push_back(dst_addr);
                seen_data.push_back(dst_data);
            end
        end
        src_valid = 1'b0;
        checks++;
        if (drop_cnt !== 16'd2) begin
            errors++; $display("FAIL drop_count got=%0d exp=2", drop_cnt);
        end
        checks++;
        if (seen_addr.size() != 2) begin
            errors++; $display("FAIL drop_frames got count=%0d exp=2", seen_addr.size());
        end else if (seen_addr[0] !== 48'd7 || seen_addr[1] !== 48'd9 ||
                     seen_data[0] !== 32'h71 || seen_data[1] !== 32'h91) begin
            errors++; $display("FAIL drop_frames got %0d/%h %0d/%h exp 7/71 9/91", seen_addr[0], seen_data[0], seen_addr[1], seen_data[1]);
        end
        checks++;
        if (max_level > 2) begin
            errors++; $display("FAIL drop_max_level got=%0d exp<=2", max_level);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        src_valid = 1'b1;
        src_addr = '0;
        src_data = 32'h1234;
        for (int i = 0; i < 65534; i++) step();
        checks++;
        if (drop_cnt !== 16'hFFFE) begin
            errors++; $display("FAIL sat_pre got=%h exp=fffe", drop_cnt);
        end
        step();
        checks++;
        if (drop_cnt !== 16'hFFFF || fifo_level !== 3'd0) begin
            errors++; $display("FAIL sat_max got drops=%h level=%0d exp ffff/0", drop_cnt, fifo_level);
        end
        step();
        src_valid = 1'b0;
        checks++;
        if (drop_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold got=%h exp=ffff", drop_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int rd_idx;
        int bad;
        do_reset();
        dst_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            src_valid = 1'b1;
            src_addr = ADDR_W'(32'h100 + k);
            src_data = DATA_W'(32'hA000 + k);
            step();
        end
        dst_ready = 1'b1;
        rd_idx = 0;
        bad = 0;
        for (int k = 2; k < 12; k++) begin
            src_addr = ADDR_W'(32'h100 + k);
            src_data = DATA_W'(32'hA000 + k);
            if (fifo_level !== 3'd2 || dst_addr !== ADDR_W'(32'h100 + rd_idx) ||
                dst_data !== DATA_W'(32'hA000 + rd_idx)) begin
                bad++;
                $display("FAIL stream_cycle%0d got level=%0d addr=%h data=%h exp 2/%h/%h",
                         k, fifo_level, dst_addr, dst_data, 32'h100 + rd_idx, 32'hA000 + rd_idx);
            end
            step();
            rd_idx++;
        end
        src_valid = 1'b0;
        checks++;
        if (bad != 0) errors++;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dst_addr !== ADDR_W'(32'h100 + rd_idx) || dst_data !== DATA_W'(32'hA000 + rd_idx)) begin
                errors++; $display("FAIL stream_tail%0d got addr=%h data=%h exp %h/%h", k, dst_addr, dst_data, 32'h100 + rd_idx, 32'hA000 + rd_idx);
            end
            step();
            rd_idx++;
        end
        checks++;
        if (dst_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL stream_empty got valid=%b level=%0d exp 0/0", dst_valid, fifo_level);
        end
    endtask

    task automatic test_mid_reset();
        dst_ready = 1'b0;
        src_valid = 1'b1;
        src_addr = '0;
        step();
        for (int k = 1; k <= 3; k++) begin
            src_addr = ADDR_W'(32'h20 + k);
            src_data = DATA_W'(32'hB0 + k);
            step();
        end
        checks++;
        if (fifo_level !== 3'd3 || drop_cnt !== 16'd1) begin
            errors++; $display("FAIL midrst_pre got level=%0d drops=%0d exp 3/1", fifo_level, drop_cnt);
        end
        rst = 1'b1;
        dst_ready = 1'b1;
        src_addr = 48'h55;
        src_data = 32'h66;
        step();
        rst = 1'b0;
        src_valid = 1'b0;
        dst_ready = 1'b0;
        checks++;
        if (fifo_level !== 3'd0 || dst_valid !== 1'b0 || dst_addr !== '0 || dst_data !== '0 ||
            drop_cnt !== '0 || src_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_post got level=%0d valid=%b addr=%h data=%h drops=%0d ready=%b exp 0/0/0/0/0/1",
                               fifo_level, dst_valid, dst_addr, dst_data, drop_cnt, src_ready);
        end
    endtask

    initial begin
        rst = 1'b1;
        src_valid = 1'b0;
        src_addr = '0;
        src_data = '0;
        dst_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_full();
        test_drop();
        test_saturation();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_core.md
Name: switch_core

Overview:
- Forwarding core that sits on the switch side of the switch interface.
- Accepts source frames (48-bit address plus 32-bit data word) through a valid/ready handshake and buffers them in a FIFO.
- Presents frames in order on the destination side through a valid/ready handshake.
- Discards frames whose address is zero and counts the discards.

Parameters:
ADDR_W, 48, address width in bits
DATA_W, 32, data width in bits
DEPTH, 4, FIFO depth in entries (power of two, at least 2)
CNT_W, 16, drop counter width in bits

Ports:
clk  input  1  clock; all logic is on its rising edge
rst  input  1  synchronous reset, active-high
src_valid  input  1  source frame present
src_ready  output  1  core can accept a source frame
src_addr  input  ADDR_W  source frame address
src_data  input  DATA_W  source frame data
dst_valid  output  1  destination frame present
dst_ready  input  1  downstream accepts the destination frame
dst_addr  output  ADDR_W  destination frame address
dst_data  output  DATA_W  destination frame data
fifo_level  output  $clog2(DEPTH)+1  number of frames currently buffered
drop_cnt  output  CNT_W  count of dropped zero-address frames

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset, sampled at a rising edge with rst=1:
  - Pointers and fifo_level go to 0; drop_cnt goes to 0.
  - All FIFO entries are cleared.
  - dst_valid=0, dst_addr=0, dst_data=0.
  - src_ready=1 from the first cycle after reset.
- Reset mid-operation: any buffered frames are discarded. A handshake in the reset cycle has no effect.
- src_ready = (fifo_level != DEPTH). It is combinational from fifo_level only and is independent of dst_ready.
- Source accept: occurs at an edge with src_valid && src_ready.
  - src_addr != 0: the frame is written at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
  - src_addr == 0: the frame is dropped and not written. drop_cnt increments and saturates at all-ones.
- src_valid with src_ready=0: no effect. No drop is counted, and the source must hold the frame.
- dst_valid = (fifo_level != 0).
- dst_addr/dst_data = entry at rd_ptr (first-word fall-through). They show 0 when the FIFO is empty, because popped entries are cleared.
- Destination pop: occurs at an edge with dst_valid && dst_ready. rd_ptr increments, wrapping modulo DEPTH, and the popped entry is cleared to 0.
- While dst_valid=1 and dst_ready=0, dst_addr and dst_data stay stable.
- Latency: a frame accepted at edge N appears on dst_* (dst_valid=1) in the cycle after edge N. This holds when it is the only buffered frame.
- Level update: fifo_level changes by +1 for a write, -1 for a pop, and 0 when both occur in the same cycle.
- Simultaneous push and pop:
  - When full, no push occurs in the same cycle (src_ready=0). The pop frees one slot, and src_ready returns to 1 the next cycle.
  - When empty, a push and a pop cannot coincide, because dst_valid=0.
  - With 0 < level < DEPTH, a push and a pop in the same cycle leave the level unchanged.
- A dropped frame arriving in the same cycle as a pop: the level decrements and drop_cnt increments.
- Ordering: frames leave strictly in acceptance order, and addr/data pairing is preserved.

Test Plan:
- Reset, then push {0x0000_1111_2222, 0xDEADBEEF} with dst_ready=1 -> in the next cycle dst_valid=1 with the same addr/data. It pops that cycle, and dst_valid=0 with dst_addr=0 in the following cycle.
- Hold dst_ready=0 and push 5 frames with addresses 1..5 -> frames 1..4 are accepted and fifo_level=4. After the 4th accept src_ready=0 and frame 5 is held. Raise dst_ready -> frames exit in order 1..5, and frame 5 is accepted the cycle after the first pop.
- Push addresses 0, 7, 0, 9 back-to-back -> drop_cnt=2 and only 7 then 9 appear on dst. fifo_level never exceeds 2.
- Preload drop_cnt to all-ones via 65535 zero-address frames, then send one more zero-address frame -> drop_cnt stays 0xFFFF.
- Fill to level 2 and stream push+pop for 10 cycles -> fifo_level stays 2, with no loss or reordering across pointer wrap.
- With the FIFO at level 3, assert rst for one cycle -> the next cycle shows fifo_level=0, dst_valid=0, dst_addr=0, dst_data=0, drop_cnt=0, src_ready=1.
